// File: rtl/mold_pkg.sv
// rtl/mold_pkg.sv - shared defaults and write-FSM state type for the Mold message FIFO
//
// Contents:
//   DEF_AXI_DATA_W  default message beat width in bits
//   DEF_AXI_KEEP_W  default byte-mask width (DEF_AXI_DATA_W/8)
//   DEF_ML_W        default Mold message length field width
//   wr_state_t      write-side FSM states (IDLE, WRITE, DROP)
package mold_pkg;

    localparam int DEF_AXI_DATA_W = 64;
    localparam int DEF_AXI_KEEP_W = 8;
    localparam int DEF_ML_W       = 16;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/mold_msg_fifo_if.sv
// rtl/mold_msg_fifo_if.sv - message-in / beat-out signal bundle for mold_msg_fifo
//
// Signals:
//   msg_v, msg_start, msg_len, msg_mask, msg_data   inbound beats (no backpressure)
//   out_v, out_ready, out_start, out_last,
//   out_mask, out_data                               outbound committed beats
//   drop                                             discard pulse
// Modports:
//   master  producer/consumer side that drives beats in and accepts beats out
//   slave   FIFO side
interface mold_msg_fifo_if #(
    parameter int AXI_DATA_W = mold_pkg::DEF_AXI_DATA_W,
    parameter int AXI_KEEP_W = mold_pkg::DEF_AXI_KEEP_W,
    parameter int ML_W       = mold_pkg::DEF_ML_W
);
    logic                  msg_v;
    logic                  msg_start;
    logic [ML_W-1:0]       msg_len;
    logic [AXI_KEEP_W-1:0] msg_mask;
    logic [AXI_DATA_W-1:0] msg_data;
    logic                  out_v;
    logic                  out_ready;
    logic                  out_start;
    logic                  out_last;
    logic [AXI_KEEP_W-1:0] out_mask;
    logic [AXI_DATA_W-1:0] out_data;
    logic                  drop;

    modport master (
        output msg_v, msg_start, msg_len, msg_mask, msg_data, out_ready,
        input  out_v, out_start, out_last, out_mask, out_data, drop
    );

    modport slave (
        input  msg_v, msg_start, msg_len, msg_mask, msg_data, out_ready,
        output out_v, out_start, out_last, out_mask, out_data, drop
    );
endinterface

// File: rtl/mold_fifo_ram.sv
// rtl/mold_fifo_ram.sv - FIFO storage, one synchronous write port, one asynchronous read port
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write entry
//   raddr  in   read address
//   rdata  out  entry at raddr (combinational)
module mold_fifo_ram #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage has no reset: a rewound or reset pointer set makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mold_msg_fifo.sv
// rtl/mold_msg_fifo.sv - whole-message FIFO for Mold messages with truncation/overflow discard
//
// Ports:
//   clk, nreset                      clock, asynchronous active-low reset
//   mold_msg_v_i .. mold_msg_data_i  inbound beats, no backpressure; len sampled on start
//   out_v_o .. out_data_o, out_ready_i
//                                    outbound beats of committed messages only
//   drop_o                           one-cycle pulse per discarded message
//   drop_cnt_o                       saturating discard count (only with MOLD_FIFO_STATS_EN)
// Build option: define MOLD_FIFO_STATS_EN to add drop_cnt_o and its counter.
module mold_msg_fifo
    import mold_pkg::*;
#(
    parameter int AXI_DATA_W = DEF_AXI_DATA_W,
    parameter int AXI_KEEP_W = DEF_AXI_KEEP_W,
    parameter int ML_W       = DEF_ML_W,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  mold_msg_v_i,
    input  logic                  mold_msg_start_i,
    input  logic [ML_W-1:0]       mold_msg_len_i,
    input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
    output logic                  out_v_o,
    input  logic                  out_ready_i,
    output logic                  out_start_o,
    output logic                  out_last_o,
    output logic [AXI_KEEP_W-1:0] out_mask_o,
    output logic [AXI_DATA_W-1:0] out_data_o,
    output logic                  drop_o
`ifdef MOLD_FIFO_STATS_EN
    ,
    output logic [15:0]           drop_cnt_o
`endif
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int EW = 2 + AXI_KEEP_W + AXI_DATA_W;
    localparam logic [PW-1:0]   DEPTH_P    = PW'(DEPTH);
    localparam logic [ML_W-1:0] KEEP_BYTES = ML_W'(AXI_KEEP_W);

    wr_state_t       state, state_n, st_eff;
    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0]   wr_n, commit_n, wr_base;
    logic [ML_W-1:0] rem, rem_n, eff_rem;
    logic            beat_last, full_eff, we, drop_n, pop;
    logic [EW-1:0]   wdata, rdata;

    // A start beat carries its own length; later beats count down the stored remainder.
    assign eff_rem   = mold_msg_start_i ? mold_msg_len_i : rem;
    assign beat_last = (eff_rem <= KEEP_BYTES);
    assign wdata     = {mold_msg_start_i, beat_last, mold_msg_mask_i, mold_msg_data_i};

    always_comb begin
        state_n  = state;
        st_eff   = state;
        wr_n     = wr_ptr;
        wr_base  = wr_ptr;
        commit_n = commit_ptr;
        rem_n    = rem;
        we       = 1'b0;
        drop_n   = 1'b0;
        full_eff = 1'b0;
        if (mold_msg_v_i) begin
            // A start beat mid-message truncates the open message: rewind, flag the
            // drop, then treat this beat as a fresh start from IDLE.
            if (mold_msg_start_i && state != WR_IDLE) begin
                drop_n  = 1'b1;
                wr_base = commit_ptr;
                wr_n    = commit_ptr;
                st_eff  = WR_IDLE;
            end
            // Full uses the read pointer before any same-cycle pop.
            full_eff = ((wr_base - rd_ptr) == DEPTH_P);
            rem_n    = beat_last ? '0 : eff_rem - KEEP_BYTES;
            case (st_eff)
                WR_IDLE: begin
                    state_n = WR_IDLE;
                    if (!mold_msg_start_i) begin
                        drop_n = 1'b1;
                        rem_n  = '0;
                    end else if (mold_msg_len_i == '0) begin
                        rem_n = '0;
                    end else if (full_eff) begin
                        if (beat_last) drop_n = 1'b1;
                        else           state_n = WR_DROP;
                    end else begin
                        we   = 1'b1;
                        wr_n = wr_base + 1'b1;
                        if (beat_last) commit_n = wr_base + 1'b1;
                        else           state_n  = WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    if (full_eff) begin
                        wr_n = commit_ptr;
                        if (beat_last) begin
                            drop_n  = 1'b1;
                            state_n = WR_IDLE;
                        end else begin
                            state_n = WR_DROP;
                        end
                    end else begin
                        we   = 1'b1;
                        wr_n = wr_ptr + 1'b1;
                        if (beat_last) begin
                            commit_n = wr_ptr + 1'b1;
                            state_n  = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (beat_last) begin
                        drop_n  = 1'b1;
                        state_n = WR_IDLE;
                    end
                end
                default: state_n = WR_IDLE;
            endcase
        end
    end

    assign out_v_o = (commit_ptr != rd_ptr);
    assign pop     = out_v_o & out_ready_i;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rem        <= '0;
            drop_o     <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_n;
            commit_ptr <= commit_n;
            rem        <= rem_n;
            drop_o     <= drop_n;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef MOLD_FIFO_STATS_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            drop_cnt_o <= '0;
        end else if (drop_o && drop_cnt_o != 16'hFFFF) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif

    mold_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_base[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    assign out_start_o = rdata[EW-1];
    assign out_last_o  = rdata[EW-2];
    assign out_mask_o  = rdata[AXI_DATA_W +: AXI_KEEP_W];
    assign out_data_o  = rdata[AXI_DATA_W-1:0];
endmodule

// File: doc/mold_msg_fifo.md
MOLD_MSG_FIFO -- requirements
Module: mold_msg_fifo

Interface
REQ-001 SHALL have parameter AXI_DATA_W, default 64, message data beat width in bits.
REQ-002 SHALL have parameter AXI_KEEP_W, default 8, byte-mask width (AXI_DATA_W/8).
REQ-003 SHALL have parameter ML_W, default 16, Mold message length field width.
REQ-004 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >=4).
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- mold_msg_v_i  in  1  input beat valid; no backpressure.
- mold_msg_start_i  in  1  first beat of a message.
- mold_msg_len_i  in  ML_W  message byte length, sampled on start.
- mold_msg_mask_i  in  AXI_KEEP_W  byte-valid mask.
- mold_msg_data_i  in  AXI_DATA_W  message bytes.
- out_v_o  out  1  output beat valid.
- out_ready_i  in  1  consumer ready.
- out_start_o  out  1  first beat of the message.
- out_last_o  out  1  last beat of the message.
- out_mask_o  out  AXI_KEEP_W  byte mask.
- out_data_o  out  AXI_DATA_W  data.
- drop_o  out  1  one-cycle pulse when a message is discarded.
- drop_cnt_o  out  16  saturating discard count (MOLD_FIFO_STATS_EN only).

Function
REQ-006 SHALL store beats as {start, last, mask, data} entries; read/write pointers are log2(DEPTH)+1 bits; full when wr-rd == DEPTH; empty when commit == rd.
REQ-007 SHALL keep a commit pointer; the read side SHALL see only committed entries (whole messages only).
REQ-008 SHALL track remaining bytes: on a start beat, rem = len; a beat is last when rem <= AXI_KEEP_W; otherwise rem -= AXI_KEEP_W per valid beat.
REQ-009 SHALL run a write FSM with states IDLE, WRITE and DROP.
- IDLE: a start beat goes to WRITE, or to DROP if full.
- A start beat that is also last commits immediately and stays in IDLE.
- A non-start beat in IDLE is ignored and counted as a discard.
REQ-010 SHALL, in WRITE, on the last beat set commit = wr+1 and return to IDLE.
REQ-011 SHALL, on a beat arriving in WRITE while full, rewind wr to commit, go to DROP, and consume remaining beats without writing.
REQ-012 SHALL, on the last beat in DROP, return to IDLE and pulse drop_o.
REQ-013 SHALL, on a start beat in WRITE or DROP (truncated message), rewind wr to commit, pulse drop_o, and process the beat as a new start from IDLE in the same cycle.
REQ-014 SHALL discard a start beat with len == 0: no entry is written, drop_o does not pulse, and state stays IDLE.
REQ-015 SHALL make a committed message visible at out_v_o the cycle after its last beat is written (latency 1 when empty).
REQ-016 SHALL pop on out_v_o & out_ready_i; out_* SHALL hold stable while out_v_o & ~out_ready_i.
REQ-017 SHALL allow write, commit and pop in the same cycle; full is evaluated with the pre-pop read pointer.
REQ-018 SHALL wrap pointers modulo 2*DEPTH with no lost entries.

Reset
REQ-019 SHALL, with nreset low, asynchronously clear wr, commit and rd pointers, set the FSM to IDLE, clear rem, and drive out_v_o=0, drop_o=0, drop_cnt_o=0.
REQ-020 SHALL discard any partially written or uncommitted message on reset mid-message; storage contents need not be cleared.

Configuration
REQ-021 SHALL, with MOLD_FIFO_STATS_EN defined, implement drop_cnt_o, incrementing on each drop_o pulse and saturating at 16'hFFFF.
REQ-022 SHALL, without MOLD_FIFO_STATS_EN, omit the drop_cnt_o port and its counter; all other behaviour is identical.

Structure
REQ-023 SHALL take AXI_DATA_W, AXI_KEEP_W and ML_W defaults and the FSM state enum from shared package mold_pkg.
REQ-024 SHALL implement storage as sub-module mold_fifo_ram (1 write, 1 asynchronous read port).

Verification
REQ-025 SHALL cover: a 20-byte message (3 beats, masks FF/FF/0F) into an empty FIFO -> out_v_o rises 1 cycle after beat 3, giving start/-/last beats with identical data.
REQ-026 SHALL cover: a 6-byte single-beat message -> one entry with start=1, last=1, mask=3F.
REQ-027 SHALL cover: DEPTH=16, out_ready_i=0, 17-beat message -> nothing is visible, drop_o pulses once, pointers equal the pre-message values; STATS build shows drop_cnt_o=1.
REQ-028 SHALL cover: a 3-beat message restarted by a start at beat 2 -> first message discarded, second delivered intact.
REQ-029 SHALL cover: back-to-back 8-byte messages with out_ready_i toggled randomly across 3 pointer wraps -> in-order, loss-free output, with out_* stable while stalled.
REQ-030 SHALL cover: nreset asserted mid-message -> out_v_o=0 immediately; after release the next message is delivered normally.
